// File: rtl/addsub_pkg.sv
//------------------------------------------------------------------------------
// Module   : addsub_pkg
// Brief    : Shared constants and the state encoding for the addsub accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package addsub_pkg;

  localparam int   ADDSUB_W = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub.sv
//------------------------------------------------------------------------------
// Module   : addsub
// Brief    : Combinational two's-complement adder/subtractor (result = a +/- b).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mode,
  output logic [WIDTH-1:0] result
);

  assign result = (mode == MODE_SUB) ? (operand_a - operand_b) : (operand_a + operand_b);

endmodule

`default_nettype wire

// File: rtl/addsub_ovf_detect.sv
//------------------------------------------------------------------------------
// Module   : addsub_ovf_detect
// Brief    : Signed-overflow detector for one add/sub operation (a, b, r, mode).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module addsub_ovf_detect
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  input  logic             mode,
  output logic             ovf
);

  logic w_signs_risky;

  // Add can only overflow with like signs, subtract only with unlike signs.
  assign w_signs_risky = (mode == MODE_SUB) ? (a[WIDTH-1] != b[WIDTH-1])
                                            : (a[WIDTH-1] == b[WIDTH-1]);
  assign ovf = w_signs_risky && (r[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/addsub_acc.sv
//------------------------------------------------------------------------------
// Module   : addsub_acc
// Brief    : Signed accumulator driving an external addsub unit over a
//            valid/ready stream, with sticky overflow and optional saturation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module addsub_acc
  import addsub_pkg::*;
#(
  parameter int WIDTH    = ADDSUB_W,
  parameter int N_OPS    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic             in_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_mode,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic [3:0]       op_count,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0]       C_LAST_OP = 4'(N_OPS - 1);
  localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [3:0]       r_op_count;
  logic             r_done;

  logic             w_accept;
  logic             w_op_ovf;
  logic [WIDTH-1:0] w_next_acc;

  assign alu_a    = r_acc;
  assign alu_b    = in_operand;
  assign alu_mode = in_mode;

  assign in_ready = (r_state == RUN);
  assign busy     = (r_state == RUN);
  assign w_accept = in_valid && in_ready;

  addsub_ovf_detect #(
    .WIDTH (WIDTH)
  ) u_ovf_detect (
    .a    (r_acc),
    .b    (in_operand),
    .r    (alu_result),
    .mode (in_mode),
    .ovf  (w_op_ovf)
  );

  generate
    if (SATURATE != 0) begin : g_saturate
      // Overflow direction follows the accumulator's sign before the operation.
      assign w_next_acc = !w_op_ovf      ? alu_result :
                          r_acc[WIDTH-1] ? C_MAX_NEG  : C_MAX_POS;
    end else begin : g_wrap
      assign w_next_acc = alu_result;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_op_count <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_op_count <= 4'd0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_acc      <= w_next_acc;
            r_ovf      <= r_ovf | w_op_ovf;
            r_op_count <= r_op_count + 4'd1;
            if (r_op_count == C_LAST_OP) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign acc      = r_acc;
  assign ovf      = r_ovf;
  assign op_count = r_op_count;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_addsub_acc.sv
//------------------------------------------------------------------------------
// Module   : tb_addsub_acc
// Brief    : Scoreboard bench running a wrapping and a saturating accumulator
//            side by side, each with its own addsub unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub_acc;
  import addsub_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_operand = 4'd0;
  logic       in_mode = 1'b0;

  logic       rdy_w, busy_w, done_w, ovf_w, amode_w;
  logic [3:0] a_w, b_w, res_w, acc_w, cnt_w;
  logic       rdy_s, busy_s, done_s, ovf_s, amode_s;
  logic [3:0] a_s, b_s, res_s, acc_s, cnt_s;

  always #5 clk = ~clk;

  addsub_acc #(.WIDTH(4), .N_OPS(8), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_w),
    .in_operand(in_operand), .in_mode(in_mode), .alu_a(a_w), .alu_b(b_w),
    .alu_mode(amode_w), .alu_result(res_w), .acc(acc_w), .ovf(ovf_w),
    .op_count(cnt_w), .busy(busy_w), .done(done_w));
  addsub #(.WIDTH(4)) alu_w (.operand_a(a_w), .operand_b(b_w), .mode(amode_w), .result(res_w));

  addsub_acc #(.WIDTH(4), .N_OPS(8), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_s),
    .in_operand(in_operand), .in_mode(in_mode), .alu_a(a_s), .alu_b(b_s),
    .alu_mode(amode_s), .alu_result(res_s), .acc(acc_s), .ovf(ovf_s),
    .op_count(cnt_s), .busy(busy_s), .done(done_s));
  addsub #(.WIDTH(4)) alu_s (.operand_a(a_s), .operand_b(b_s), .mode(amode_s), .result(res_s));

  typedef struct {
    logic [3:0] acc_w;
    logic       ovf_w;
    logic [3:0] acc_s;
    logic       ovf_s;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted item on the wrapping DUT retires one scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    if (!rst && in_valid && rdy_w) begin
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: accept seen with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("acc_wrap", int'(acc_w), int'(e.acc_w));
        chk("ovf_wrap", int'(ovf_w), int'(e.ovf_w));
        chk("acc_sat",  int'(acc_s), int'(e.acc_s));
        chk("ovf_sat",  int'(ovf_s), int'(e.ovf_s));
        chk("cnt_wrap", int'(cnt_w), int'(e.cnt));
        chk("cnt_sat",  int'(cnt_s), int'(e.cnt));
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_cnt = 4'd0;
    chk("start_busy", int'(busy_w & busy_s), 1);
    chk("start_acc", int'({acc_w, acc_s}), 0);
    chk("start_cnt", int'(cnt_w), 0);
  endtask

  task automatic abort_run();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One item presented for exactly one accepting edge, then one idle cycle.
  task automatic do_op(input logic [3:0] b, input logic m,
                       input logic [3:0] eaw, input logic eow,
                       input logic [3:0] eas, input logic eos);
    int n = 0;
    exp_t e;
    exp_cnt = exp_cnt + 4'd1;
    e.acc_w = eaw; e.ovf_w = eow; e.acc_s = eas; e.ovf_s = eos; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b1;
    in_operand = b;
    in_mode = m;
    while (!rdy_w && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_w) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: in_ready never rose, got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic exp_t model(input int a, input int b, input logic m);
    exp_t e;
    int t = m ? a - b : a + b;
    logic o = (t > 7) || (t < -8);
    e.acc_w = 4'(t);
    e.ovf_w = o;
    e.acc_s = (t > 7) ? 4'd7 : (t < -8) ? 4'b1000 : 4'(t);
    e.ovf_s = o;
    e.cnt   = 4'd0;
    return e;
  endfunction

  initial begin
    exp_t g;
    repeat (2) @(negedge clk);
    chk("rst_acc", int'(acc_w), 0);
    chk("rst_ovf", int'(ovf_w | ovf_s), 0);
    chk("rst_cnt", int'(cnt_w), 0);
    chk("rst_busy", int'(busy_w), 0);
    chk("rst_ready", int'(rdy_w), 0);
    chk("rst_done", int'(done_w), 0);
    rst = 1'b0;

    // Wrap/saturate on +3,+4,+1 then five idle adds to complete the run.
    do_start();
    do_op(4'd3, MODE_ADD, 4'd3, 1'b0, 4'd3, 1'b0);
    chk("gap_hold_cnt", int'(cnt_w), 1);
    do_op(4'd4, MODE_ADD, 4'd7, 1'b0, 4'd7, 1'b0);
    do_op(4'd1, MODE_ADD, 4'b1000, 1'b1, 4'd7, 1'b1);
    for (int i = 0; i < 4; i++) do_op(4'd0, MODE_ADD, 4'b1000, 1'b1, 4'd7, 1'b1);
    chk("pre_last_done", int'(done_w), 0);
    do_op(4'd0, MODE_ADD, 4'b1000, 1'b1, 4'd7, 1'b1);
    chk("done_pulse", int'(done_w & done_s), 1);
    chk("done_ready", int'(rdy_w | rdy_s), 0);
    chk("done_busy", int'(busy_w), 0);
    @(negedge clk);
    chk("idle_done_low", int'(done_w | done_s), 0);
    chk("idle_ready", int'(rdy_w), 0);
    in_valid = 1'b1;
    in_operand = 4'd1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_hold_acc", int'(acc_w), 8);
    chk("idle_hold_cnt", int'(cnt_w), 8);
    chk("idle_hold_ovf", int'(ovf_w), 1);

    // 0 - (-8) overflows.
    do_start();
    do_op(4'b1000, MODE_SUB, 4'b1000, 1'b1, 4'd7, 1'b1);
    abort_run();
    // -8 - 0 does not.
    do_start();
    do_op(4'b1000, MODE_ADD, 4'b1000, 1'b0, 4'b1000, 1'b0);
    do_op(4'd0, MODE_SUB, 4'b1000, 1'b0, 4'b1000, 1'b0);
    abort_run();
    // +7 + 7.
    do_start();
    do_op(4'd7, MODE_ADD, 4'd7, 1'b0, 4'd7, 1'b0);
    do_op(4'd7, MODE_ADD, 4'b1110, 1'b1, 4'd7, 1'b1);
    abort_run();
    // Repeated -1 walks down to -8 exactly on the last op.
    do_start();
    for (int i = 1; i <= 8; i++)
      do_op(4'd1, MODE_SUB, 4'(-i), 1'b0, 4'(-i), 1'b0);
    chk("sub_run_done", int'(done_s), 1);

    // Asynchronous reset between edges.
    do_start();
    do_op(4'd2, MODE_ADD, 4'd2, 1'b0, 4'd2, 1'b0);
    do_op(4'd2, MODE_ADD, 4'd4, 1'b0, 4'd4, 1'b0);
    do_op(4'd1, MODE_ADD, 4'd5, 1'b0, 4'd5, 1'b0);
    chk("pre_rst_acc", int'(acc_w), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_acc", int'({acc_w, acc_s}), 0);
    chk("async_ovf", int'(ovf_w | ovf_s), 0);
    chk("async_cnt", int'(cnt_w), 0);
    chk("async_busy", int'(busy_w | busy_s), 0);
    #1 rst = 1'b0;

    // Exhaustive single operation after a preload of a.
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        for (int m = 0; m < 2; m++) begin
          do_start();
          do_op(4'(a), MODE_ADD, 4'(a), 1'b0, 4'(a), 1'b0);
          g = model(a, b, 1'(m));
          do_op(4'(b), 1'(m), g.acc_w, g.ovf_w, g.acc_s, g.ovf_s);
          abort_run();
        end
      end
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
